// File: rtl/mem_xfer_pkg.sv
// Shared types and helpers for the memory transfer unit.
package mem_xfer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  // Access size encoding; the reserved code 3 behaves as a word.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when the low address bits do not suit the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = ofs[0];
      default: mis = (ofs != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_xfer_unit_align.sv
// Byte-lane steering: enables, write replication, read extraction and extension.
module mem_lane_align
  import mem_xfer_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic              sgn_i,
  input  logic [1:0]        ofs_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Pick the addressed byte and half out of the returned word.
  always_comb begin
    rbyte = rdata_i[7:0];
    case (ofs_i)
      2'd0:    rbyte = rdata_i[7:0];
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      default: rbyte = rdata_i[31:24];
    endcase
    rhalf = ofs_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Lane enables, replicated write data and extended read data per size.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << ofs_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sgn_i & rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        be_o    = ofs_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sgn_i & rhalf[15]}}, rhalf};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_xfer_unit.sv
// MAR/MDR load unit: latches a request, runs the MOV/MFC handshake with timeout,
// and aligns/extends read data into MDR.
module mem_xfer_unit
  import mem_xfer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_mfc,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              mov_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rdata_c;

  // Lane steering works only from latched request state.
  mem_lane_align u_align (
    .size_i  (size_q),
    .sgn_i   (sgn_q),
    .ofs_i   (mar_q[1:0]),
    .wdata_i (mdr_q),
    .rdata_i (mem_rdata),
    .be_o    (be_c),
    .wdata_o (wdata_c),
    .rdata_o (rdata_c)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  // Memory-side outputs are quiet unless a request is in flight.
  assign mem_mov   = mov_q;
  assign mem_rw    = rw_q;
  assign mem_addr  = {mar_q[ADDR_W-1:2], 2'b00};
  assign mem_be    = mov_q ? be_c : '0;
  assign mem_wdata = mov_q ? wdata_c : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // Transfer FSM with its datapath registers.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      mov_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mar_q  <= addr_in;
            mdr_q  <= wdata_in;
            rw_q   <= rw;
            size_q <= size;
            sgn_q  <= sgn;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (is_misaligned(size, addr_in[1:0])) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= REQ;
              mov_q   <= 1'b1;
              err_q   <= 1'b0;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_d;
          if (mem_mfc) begin
            if (rw_q) begin
              mdr_q <= rdata_c;
            end
            state_q <= DONE;
            mov_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= DONE;
            mov_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          mov_q   <= 1'b0;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xfer_unit.sv
// Scoreboard bench for mem_xfer_unit: driver queues expected results, monitor checks at done.
module tb_mem_xfer_unit;

  typedef struct {
    logic        err;
    logic [31:0] mdr;
    int          mov;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rw;
    logic [31:0] mar;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        start;
  logic        rw;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        mem_mov;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_mfc;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mar_q;
  logic [31:0] mdr_q;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  mem_xfer_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .start     (start),
    .rw        (rw),
    .size      (size),
    .sgn       (sgn),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .mem_mov   (mem_mov),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_mfc   (mem_mfc),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mar_q     (mar_q),
    .mdr_q     (mdr_q)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic e, input logic [31:0] mdr, input int mov,
                              input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] wd, input logic r, input logic [31:0] mar);
    exp_t x;
    x.err = e; x.mdr = mdr; x.mov = mov; x.addr = a;
    x.be = be; x.wd = wd; x.rw = r; x.mar = mar;
    return x;
  endfunction

  // One transfer; mfc_at = REQ cycle on which MFC is raised (0 = never).
  task automatic xfer(input logic r, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input int mfc_at,
                      input logic [31:0] rd, input logic hold, input exp_t e);
    int  n;
    logic got;
    exp_q.push_back(e);
    @(negedge CLK);
    start = 1'b1; rw = r; size = sz; sgn = sg; addr_in = a; wdata_in = wd;
    mem_rdata = rd; mem_mfc = 1'b0;
    @(negedge CLK);
    if (hold) begin
      addr_in  = ~a;
      wdata_in = ~wd;
    end else begin
      start = 1'b0;
    end
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (mem_mov) begin
        n++;
        mem_mfc = (n == mfc_at);
      end else begin
        mem_mfc = 1'b0;
      end
      @(negedge CLK);
    end
    start   = 1'b0;
    mem_mfc = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done for addr %h expected done within 40 cycles", a);
    end
  endtask

  // Monitor: counts MOV/busy cycles and checks the queued expectation at each done.
  initial begin
    exp_t e;
    int mov_cnt;
    int busy_cnt;
    logic [31:0] c_addr;
    logic [31:0] c_wd;
    logic [3:0]  c_be;
    logic        c_rw;
    mov_cnt = 0; busy_cnt = 0;
    c_addr = '0; c_wd = '0; c_be = '0; c_rw = 1'b0;
    forever begin
      @(negedge CLK);
      if (!busy) begin
        mov_cnt  = 0;
        busy_cnt = 0;
      end else begin
        busy_cnt++;
        if (mem_mov) begin
          mov_cnt++;
          if (mov_cnt == 1) begin
            c_addr = mem_addr; c_be = mem_be; c_wd = mem_wdata; c_rw = mem_rw;
          end
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no transfer pending");
        end else begin
          e = exp_q.pop_front();
          chk("err", 32'(err), 32'(e.err));
          chk("mdr_q", mdr_q, e.mdr);
          chk("mar_q", mar_q, e.mar);
          chk("mov_cycles", 32'(mov_cnt), 32'(e.mov));
          chk("latency", 32'(busy_cnt), 32'(e.mov + 1));
          if (e.mov > 0) begin
            chk("mem_addr", c_addr, e.addr);
            chk("mem_be", 32'(c_be), 32'(e.be));
            chk("mem_wdata", c_wd, e.wd);
            chk("mem_rw", 32'(c_rw), 32'(e.rw));
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    RSTn = 1'b0; start = 1'b0; rw = 1'b0; size = 2'd0; sgn = 1'b0;
    addr_in = '0; wdata_in = '0; mem_mfc = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge CLK);
    chk("rst_mem_mov", 32'(mem_mov), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mar", mar_q, 32'd0);
    chk("rst_mdr", mdr_q, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    RSTn = 1'b1;

    // MFC while idle must not start anything.
    @(negedge CLK);
    mem_mfc = 1'b1;
    @(negedge CLK);
    mem_mfc = 1'b0;
    chk("idle_mfc_busy", 32'(busy), 32'd0);

    // word read, MFC on 3rd REQ cycle
    xfer(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 3, 32'hDEADBEEF, 1'b0,
         mk(1'b0, 32'hDEADBEEF, 3, 32'h100, 4'hF, 32'h12345678, 1'b1, 32'h100));
    // byte reads at lane 3, signed then unsigned
    xfer(1'b1, 2'd0, 1'b1, 32'h103, 32'h0, 1, 32'h80112233, 1'b0,
         mk(1'b0, 32'hFFFFFF80, 1, 32'h100, 4'b1000, 32'h0, 1'b1, 32'h103));
    xfer(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 1, 32'h80112233, 1'b0,
         mk(1'b0, 32'h00000080, 1, 32'h100, 4'b1000, 32'h0, 1'b1, 32'h103));
    // half reads, upper negative and lower positive
    xfer(1'b1, 2'd1, 1'b1, 32'h102, 32'h0, 2, 32'h80017FFF, 1'b0,
         mk(1'b0, 32'hFFFF8001, 2, 32'h100, 4'b1100, 32'h0, 1'b1, 32'h102));
    xfer(1'b1, 2'd1, 1'b1, 32'h100, 32'h0, 1, 32'h80017FFF, 1'b0,
         mk(1'b0, 32'h00007FFF, 1, 32'h100, 4'b0011, 32'h0, 1'b1, 32'h100));
    // half write at 0x202, byte write at 0x301; MDR keeps write data
    xfer(1'b0, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 2, 32'hFFFFFFFF, 1'b0,
         mk(1'b0, 32'h0000ABCD, 2, 32'h200, 4'b1100, 32'hABCDABCD, 1'b0, 32'h202));
    xfer(1'b0, 2'd0, 1'b0, 32'h301, 32'h123456A5, 1, 32'hFFFFFFFF, 1'b0,
         mk(1'b0, 32'h123456A5, 1, 32'h300, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h301));
    // misaligned word and half: error, no MOV
    xfer(1'b1, 2'd2, 1'b0, 32'h101, 32'hCAFEF00D, 1, 32'h0, 1'b0,
         mk(1'b1, 32'hCAFEF00D, 0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h101));
    xfer(1'b1, 2'd1, 1'b0, 32'h0FF, 32'h11112222, 1, 32'h0, 1'b0,
         mk(1'b1, 32'h11112222, 0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0FF));
    // reserved size acts as word
    xfer(1'b1, 2'd3, 1'b0, 32'h104, 32'h0, 1, 32'h01020304, 1'b0,
         mk(1'b0, 32'h01020304, 1, 32'h104, 4'hF, 32'h0, 1'b1, 32'h104));
    // timeout: 16 MOV cycles then error; MFC on the 16th cycle wins
    xfer(1'b1, 2'd2, 1'b0, 32'h400, 32'h77, 0, 32'hAAAAAAAA, 1'b0,
         mk(1'b1, 32'h77, 16, 32'h400, 4'hF, 32'h77, 1'b1, 32'h400));
    xfer(1'b1, 2'd2, 1'b0, 32'h400, 32'h77, 16, 32'h5A5A5A5A, 1'b0,
         mk(1'b0, 32'h5A5A5A5A, 16, 32'h400, 4'hF, 32'h77, 1'b1, 32'h400));
    // start held high while busy (REQ and DONE) is ignored
    xfer(1'b1, 2'd2, 1'b0, 32'h600, 32'h99, 2, 32'h13572468, 1'b1,
         mk(1'b0, 32'h13572468, 2, 32'h600, 4'hF, 32'h99, 1'b1, 32'h600));
    xfer(1'b0, 2'd2, 1'b0, 32'h602, 32'h42, 0, 32'h0, 1'b1,
         mk(1'b1, 32'h42, 0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h602));
    @(negedge CLK);
    chk("idle_after_hold_busy", 32'(busy), 32'd0);
    chk("idle_after_hold_mar", mar_q, 32'h602);

    // reset in the middle of REQ
    @(negedge CLK);
    start = 1'b1; rw = 1'b1; size = 2'd2; sgn = 1'b0;
    addr_in = 32'h500; wdata_in = 32'h55; mem_mfc = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    chk("pre_rst_mov", 32'(mem_mov), 32'd1);
    RSTn = 1'b0;
    @(negedge CLK);
    chk("mid_rst_mov", 32'(mem_mov), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mdr", mdr_q, 32'd0);
    chk("mid_rst_mar", mar_q, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    RSTn = 1'b1;
    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
